// File: rtl/temporal_encoder_pkg.sv
// Shared constants, state encoding and sizing helper for the temporal n-gram encoder.
package temporal_encoder_pkg;

    localparam int unsigned HV_DIMENSION_DEF = 8;
    localparam int unsigned NGRAM_SIZE_DEF   = 3;

    // Smallest r with 2**r >= v; sizes the fill counter to hold 0..NGRAM_SIZE.
    function automatic int unsigned ceil_log2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_COMPUTE       = 2'd1,
        ST_OUTPUT_STABLE = 2'd2
    } state_e;

endpackage

// File: rtl/temporal_encoder_hv_rotate.sv
// Combinational cyclic rotation rho^SHIFT: bit k moves to bit (k+SHIFT) mod HV_DIMENSION.
module hv_rotate #(
    parameter int unsigned HV_DIMENSION = 8,
    parameter int unsigned SHIFT        = 0
) (
    input  logic [0:HV_DIMENSION-1] Hv_DI,
    output logic [0:HV_DIMENSION-1] Hv_DO
);

    for (genvar k = 0; k < HV_DIMENSION; k++) begin : g_bit
        assign Hv_DO[(k + SHIFT) % HV_DIMENSION] = Hv_DI[k];
    end

endmodule

// File: rtl/temporal_encoder.sv
// Temporal n-gram encoder: binds the last NGRAM_SIZE spatial hypervectors by rotate+XOR.
// TEMPORAL_SLIDING_EN defined selects sliding windows; undefined gives non-overlapping windows.
module temporal_encoder
    import temporal_encoder_pkg::*;
#(
    parameter int unsigned HV_DIMENSION = HV_DIMENSION_DEF,
    parameter int unsigned NGRAM_SIZE   = NGRAM_SIZE_DEF
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic                    FlushIn_SI,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [0:HV_DIMENSION-1] HypervectorOut_DO
);

    localparam int unsigned FILL_W = ceil_log2(NGRAM_SIZE + 1);

    state_e                    state_q;
    logic                      ready_q;
    logic                      valid_q;
    logic [0:HV_DIMENSION-1]   out_q;
    logic [FILL_W-1:0]         fill_q;
    logic [0:HV_DIMENSION-1]   hist_q [NGRAM_SIZE];
    logic [0:HV_DIMENSION-1]   rot    [NGRAM_SIZE];
    logic [0:HV_DIMENSION-1]   ngram_d;

    // hist_q[0] is the newest input and is rotated by its age.
    for (genvar i = 0; i < NGRAM_SIZE; i++) begin : g_rot
        hv_rotate #(
            .HV_DIMENSION (HV_DIMENSION),
            .SHIFT        (i)
        ) u_rot (
            .Hv_DI (hist_q[i]),
            .Hv_DO (rot[i])
        );
    end

    always_comb begin
        ngram_d = '0;
        for (int i = 0; i < NGRAM_SIZE; i++) ngram_d = ngram_d ^ rot[i];
    end

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            out_q   <= '0;
            fill_q  <= '0;
            for (int i = 0; i < NGRAM_SIZE; i++) hist_q[i] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ValidIn_SI) begin
                        // A simultaneous flush empties the window before this input lands.
                        hist_q[0] <= HypervectorIn_DI;
                        for (int i = 1; i < NGRAM_SIZE; i++)
                            hist_q[i] <= FlushIn_SI ? '0 : hist_q[i-1];
                        if (FlushIn_SI)
                            fill_q <= FILL_W'(1);
                        else if (fill_q != FILL_W'(NGRAM_SIZE))
                            fill_q <= fill_q + FILL_W'(1);
                        state_q <= ST_COMPUTE;
                        ready_q <= 1'b0;
                    end else if (FlushIn_SI) begin
                        fill_q <= '0;
                        for (int i = 0; i < NGRAM_SIZE; i++) hist_q[i] <= '0;
                    end
                end
                ST_COMPUTE: begin
                    if (fill_q == FILL_W'(NGRAM_SIZE)) begin
                        out_q   <= ngram_d;
                        valid_q <= 1'b1;
                        state_q <= ST_OUTPUT_STABLE;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_OUTPUT_STABLE: begin
                    if (ReadyIn_SI) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
`ifndef TEMPORAL_SLIDING_EN
                        fill_q  <= '0;
                        for (int i = 0; i < NGRAM_SIZE; i++) hist_q[i] <= '0;
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ReadyOut_SO       = ready_q;
    assign ValidOut_SO       = valid_q;
    assign HypervectorOut_DO = out_q;

endmodule

// File: tb/tb_temporal_encoder.sv
// Randomized self-checking bench for temporal_encoder against a window-level reference model.
module tb_temporal_encoder;

    localparam int unsigned D = 8;
    localparam int unsigned N = 3;

    logic         Clk_CI = 1'b0;
    logic         Reset_RI = 1'b1;
    logic         ValidIn_SI = 1'b0;
    logic         ReadyOut_SO;
    logic         FlushIn_SI = 1'b0;
    logic [0:D-1] HypervectorIn_DI = '0;
    logic         ValidOut_SO;
    logic         ReadyIn_SI = 1'b0;
    logic [0:D-1] HypervectorOut_DO;

    int n_cmp = 0;
    int n_bad = 0;

    // Newest accepted hypervector at index 0; at most N entries kept.
    logic [0:D-1] mq [$];

    temporal_encoder #(
        .HV_DIMENSION (D),
        .NGRAM_SIZE   (N)
    ) dut (
        .Clk_CI            (Clk_CI),
        .Reset_RI          (Reset_RI),
        .ValidIn_SI        (ValidIn_SI),
        .ReadyOut_SO       (ReadyOut_SO),
        .FlushIn_SI        (FlushIn_SI),
        .HypervectorIn_DI  (HypervectorIn_DI),
        .ValidOut_SO       (ValidOut_SO),
        .ReadyIn_SI        (ReadyIn_SI),
        .HypervectorOut_DO (HypervectorOut_DO)
    );

    initial forever #5 Clk_CI = ~Clk_CI;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // XOR over window positions of the entry rotated by its age (bit k -> k+age mod D).
    function automatic logic [0:D-1] model_ngram();
        logic [0:D-1] acc;
        acc = '0;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < D; k++)
                acc[(k + i) % D] = acc[(k + i) % D] ^ mq[i][k];
        return acc;
    endfunction

    task automatic tick();
        @(posedge Clk_CI);
        #1;
    endtask

    // Sends one input (optionally with flush), checks the resulting handshake; returns expected n-gram.
    task automatic send_hv(input logic [0:D-1] hv, input logic fl, input int bp_cycles,
                           output logic got_out, output logic [0:D-1] ng);
        int waitc;
        waitc = 0;
        got_out = 1'b0;
        ng = '0;
        while (ReadyOut_SO !== 1'b1 && waitc < 20) begin
            tick();
            waitc++;
        end
        if (waitc >= 20) begin
            check("ready_timeout", 32'(waitc), 32'd0);
            return;
        end
        ValidIn_SI = 1'b1;
        FlushIn_SI = fl;
        HypervectorIn_DI = hv;
        tick();
        ValidIn_SI = 1'b0;
        FlushIn_SI = 1'b0;
        if (fl) mq.delete();
        mq.push_front(hv);
        if (mq.size() > N) void'(mq.pop_back());
        check("compute_valid", 32'(ValidOut_SO), 32'd0);
        check("compute_ready", 32'(ReadyOut_SO), 32'd0);
        tick();
        if (mq.size() == N) begin
            ng = model_ngram();
            got_out = 1'b1;
            check("out_valid", 32'(ValidOut_SO), 32'd1);
            check("out_data", 32'(HypervectorOut_DO), 32'(ng));
            // Backpressure with noise on inputs that must be ignored outside IDLE.
            for (int c = 0; c < bp_cycles; c++) begin
                ReadyIn_SI = 1'b0;
                FlushIn_SI = 1'($urandom_range(0, 1));
                ValidIn_SI = 1'($urandom_range(0, 1));
                HypervectorIn_DI = D'($urandom);
                tick();
                check("hold_valid", 32'(ValidOut_SO), 32'd1);
                check("hold_data", 32'(HypervectorOut_DO), 32'(ng));
                check("hold_ready", 32'(ReadyOut_SO), 32'd0);
            end
            FlushIn_SI = 1'b0;
            ValidIn_SI = 1'b0;
            ReadyIn_SI = 1'b1;
            tick();
            ReadyIn_SI = 1'b0;
            check("release_valid", 32'(ValidOut_SO), 32'd0);
            check("release_ready", 32'(ReadyOut_SO), 32'd1);
`ifndef TEMPORAL_SLIDING_EN
            mq.delete();
`endif
        end else begin
            check("warmup_valid", 32'(ValidOut_SO), 32'd0);
            check("warmup_ready", 32'(ReadyOut_SO), 32'd1);
        end
    endtask

    initial begin
        logic         go;
        logic [0:D-1] ng;
        int           r;

        repeat (2) @(posedge Clk_CI);
        #1;
        check("rst_valid", 32'(ValidOut_SO), 32'd0);
        check("rst_ready", 32'(ReadyOut_SO), 32'd1);
        check("rst_data", 32'(HypervectorOut_DO), 32'd0);
        Reset_RI = 1'b0;
        tick();

        // Warm-up window 80, 01, 00 with 5 cycles of backpressure.
        send_hv(8'h80, 1'b0, 0, go, ng);
        check("warm1_out", 32'(go), 32'd0);
        send_hv(8'h01, 1'b0, 0, go, ng);
        check("warm2_out", 32'(go), 32'd0);
        send_hv(8'h00, 1'b0, 5, go, ng);
        check("warm3_out", 32'(go), 32'd1);
        check("warm3_const", 32'(ng), 32'h000000A0);

        send_hv(8'h00, 1'b0, 0, go, ng);
`ifdef TEMPORAL_SLIDING_EN
        check("slide_const", 32'(ng), 32'h00000040);
`else
        check("fresh_out", 32'(go), 32'd0);
`endif

        // Flush with simultaneous valid after partial fill.
        Reset_RI = 1'b1;
        #1;
        Reset_RI = 1'b0;
        mq.delete();
        tick();
        send_hv(8'h5A, 1'b0, 0, go, ng);
        send_hv(8'h3C, 1'b0, 0, go, ng);
        send_hv(8'hFF, 1'b1, 0, go, ng);
        check("flush_out", 32'(go), 32'd0);
        send_hv(8'h00, 1'b0, 0, go, ng);
        send_hv(8'h00, 1'b0, 1, go, ng);
        check("flush_done", 32'(go), 32'd1);

        // Async reset while holding a result in OUTPUT_STABLE.
        send_hv(8'h11, 1'b1, 0, go, ng);
        send_hv(8'h22, 1'b0, 0, go, ng);
        ValidIn_SI = 1'b1;
        HypervectorIn_DI = 8'h44;
        tick();
        ValidIn_SI = 1'b0;
        tick();
        check("pre_rst_valid", 32'(ValidOut_SO), 32'd1);
        #2;
        Reset_RI = 1'b1;
        #1;
        check("arst_valid", 32'(ValidOut_SO), 32'd0);
        check("arst_data", 32'(HypervectorOut_DO), 32'd0);
        check("arst_ready", 32'(ReadyOut_SO), 32'd1);
        #1;
        Reset_RI = 1'b0;
        mq.delete();
        tick();
        send_hv(8'hA5, 1'b0, 0, go, ng);
        check("post_rst1", 32'(go), 32'd0);
        send_hv(8'h5A, 1'b0, 0, go, ng);
        check("post_rst2", 32'(go), 32'd0);
        send_hv(8'hC3, 1'b0, 0, go, ng);
        check("post_rst3", 32'(go), 32'd1);

        // Random traffic: occasional flush-only cycles and flush+valid.
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 11);
            if (r == 0) begin
                FlushIn_SI = 1'b1;
                tick();
                FlushIn_SI = 1'b0;
                mq.delete();
                check("flush_idle_ready", 32'(ReadyOut_SO), 32'd1);
                check("flush_idle_valid", 32'(ValidOut_SO), 32'd0);
            end else begin
                send_hv(D'($urandom), r == 1, $urandom_range(0, 4), go, ng);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
